i2c_bus_timer: RTL and testbench

- Parametrised successor to the fixed 100 kHz strobe generator.
- Produces quarter-bit phase strobes and a per-bit strobe for the I2C master engine.
- Supports run-time Standard/Fast mode selection, a raw divider override, SCL clock-stretch detection with timeout, and the heartbeat LED counter.
- Sits between the board clock/reset and i2c_top; one instance per I2C bus.

---
 rtl/i2c_bus_timer.sv | 127 ++++++++++++
 tb/tb_i2c_bus_timer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_timer.sv
// Quarter-bit phase / bit strobe generator for one I2C bus, with run-time
// Standard/Fast selection, divider override, SCL stretch detection and heartbeat LED.
`timescale 1ns/1ps
module i2c_bus_timer #(
  parameter int unsigned DIV_WIDTH       = 8,
  parameter int unsigned DIV_STD         = 25,
  parameter int unsigned DIV_FAST        = 7,
  parameter int unsigned TO_WIDTH        = 16,
  parameter int unsigned STRETCH_TIMEOUT = 50000,
  parameter int unsigned LED_WIDTH       = 24
) (
  input  logic                 clk_10MHz,
  input  logic                 areset_n,
  input  logic                 enable_i,
  input  logic                 mode_i,
  input  logic [DIV_WIDTH-1:0] div_override_i,
  input  logic                 stretch_en_i,
  input  logic                 scl_in_i,
  output logic [1:0]           phase_o,
  output logic                 phase_strobe_o,
  output logic                 bit_strobe_o,
  output logic                 stretching_o,
  output logic                 stretch_timeout_o,
  output logic [DIV_WIDTH-1:0] div_active_o,
  output logic                 led
);

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_e;

  phase_e               phase_q, phase_n;
  logic [DIV_WIDTH-1:0] presc_q, presc_n;
  logic [DIV_WIDTH-1:0] div_q, div_n, eff;
  logic                 ps_q, ps_n, bs_q, bs_n;
  logic                 to_flag_q, to_flag_n;
  logic [TO_WIDTH-1:0]  to_cnt_q, to_cnt_n;
  logic                 stretch_en_q;
  logic [1:0]           scl_sync;
  logic                 freeze;
  logic [LED_WIDTH-1:0] led_cnt;

  always_comb begin
    eff = div_override_i;
    if (div_override_i == '0)
      eff = mode_i ? DIV_WIDTH'(DIV_FAST) : DIV_WIDTH'(DIV_STD);
    if (eff < DIV_WIDTH'(2))
      eff = DIV_WIDTH'(2);
  end

  // Freeze is built only from flops (stretch enable is registered too),
  // so no input reaches stretching_o combinationally.
  always_comb begin
    freeze = stretch_en_q && !to_flag_q && (phase_q == PH2) &&
             (presc_q == '0) && !scl_sync[1];
  end

  always_ff @(posedge clk_10MHz or negedge areset_n) begin
    if (!areset_n) begin
      phase_q      <= PH0;
      presc_q      <= '0;
      div_q        <= DIV_WIDTH'(DIV_STD);
      ps_q         <= 1'b0;
      bs_q         <= 1'b0;
      to_flag_q    <= 1'b0;
      to_cnt_q     <= '0;
      stretch_en_q <= 1'b0;
      scl_sync     <= 2'b11;
    end else begin
      phase_q      <= phase_n;
      presc_q      <= presc_n;
      div_q        <= div_n;
      ps_q         <= ps_n;
      bs_q         <= bs_n;
      to_flag_q    <= to_flag_n;
      to_cnt_q     <= to_cnt_n;
      stretch_en_q <= stretch_en_i;
      scl_sync     <= {scl_sync[0], scl_in_i};
    end
  end

  always_comb begin
    phase_n   = phase_q;
    presc_n   = presc_q;
    div_n     = div_q;
    ps_n      = 1'b0;
    bs_n      = 1'b0;
    to_flag_n = to_flag_q;
    to_cnt_n  = '0;
    if (!enable_i) begin
      phase_n   = PH0;
      presc_n   = '0;
      div_n     = eff;
      to_flag_n = 1'b0;
    end else if (freeze) begin
      if (to_cnt_q == TO_WIDTH'(STRETCH_TIMEOUT - 1))
        to_flag_n = 1'b1;
      else
        to_cnt_n = to_cnt_q + TO_WIDTH'(1);
    end else if (presc_q == div_q - DIV_WIDTH'(1)) begin
      presc_n = '0;
      ps_n    = 1'b1;
      bs_n    = (phase_q == PH3);
      phase_n = phase_e'(phase_q + 2'd1);
      if (phase_q == PH3)
        div_n = eff;
    end else begin
      presc_n = presc_q + DIV_WIDTH'(1);
    end
  end

  always_comb begin
    phase_o           = phase_q;
    phase_strobe_o    = ps_q;
    bit_strobe_o      = bs_q;
    stretching_o      = freeze;
    stretch_timeout_o = to_flag_q;
    div_active_o      = div_q;
    led               = led_cnt[LED_WIDTH-1];
  end

  always_ff @(posedge clk_10MHz or negedge areset_n) begin
    if (!areset_n)
      led_cnt <= '0;
    else
      led_cnt <= led_cnt + LED_WIDTH'(1);
  end

endmodule

// File: tb/tb_i2c_bus_timer.sv
// Bench for i2c_bus_timer: deadline-based timeline model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_i2c_bus_timer;
  localparam int DW = 8, TW = 16, TO = 400, LW = 8, DSTD = 25, DFAST = 7;

  logic          clk_10MHz = 1'b0;
  logic          areset_n = 1'b0;
  logic          enable_i = 1'b1;
  logic          mode_i = 1'b0;
  logic [DW-1:0] div_override_i = '0;
  logic          stretch_en_i = 1'b0;
  logic          scl_in_i = 1'b1;
  logic [1:0]    phase_o;
  logic          phase_strobe_o, bit_strobe_o, stretching_o, stretch_timeout_o, led;
  logic [DW-1:0] div_active_o;

  i2c_bus_timer #(
    .DIV_WIDTH(DW), .DIV_STD(DSTD), .DIV_FAST(DFAST),
    .TO_WIDTH(TW), .STRETCH_TIMEOUT(TO), .LED_WIDTH(LW)
  ) dut (
    .clk_10MHz(clk_10MHz), .areset_n(areset_n), .enable_i(enable_i), .mode_i(mode_i),
    .div_override_i(div_override_i), .stretch_en_i(stretch_en_i), .scl_in_i(scl_in_i),
    .phase_o(phase_o), .phase_strobe_o(phase_strobe_o), .bit_strobe_o(bit_strobe_o),
    .stretching_o(stretching_o), .stretch_timeout_o(stretch_timeout_o),
    .div_active_o(div_active_o), .led(led)
  );

  always #50 clk_10MHz = ~clk_10MHz;

  int total = 0, bad = 0;
  bit chk_on = 1'b0;

  function automatic void check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Timeline model: cycle k, absolute cycle of the next strobe, frozen cycles push it out.
  longint m_k = 0, m_deadline = DSTD, m_led = 0;
  int     m_phase = 0, m_div = DSTD, m_run = 0;
  bit     m_ps = 0, m_bs = 0, m_frozen = 0, m_flag = 0, m_s1 = 1, m_s2 = 1;

  always @(posedge clk_10MHz or negedge areset_n) begin
    if (!areset_n) begin
      m_k = 0; m_deadline = DSTD; m_led = 0; m_phase = 0; m_div = DSTD; m_run = 0;
      m_ps = 0; m_bs = 0; m_frozen = 0; m_flag = 0; m_s1 = 1; m_s2 = 1;
    end else begin
      int eff;
      eff = (div_override_i != 0) ? int'(div_override_i) : (mode_i ? DFAST : DSTD);
      if (eff < 2) eff = 2;
      m_s2 = m_s1; m_s1 = scl_in_i;
      m_k++; m_led++;
      m_ps = 0; m_bs = 0;
      if (!enable_i) begin
        m_phase = 0; m_div = eff; m_deadline = m_k + eff;
        m_flag = 0; m_run = 0; m_frozen = 0;
      end else begin
        if (m_frozen) begin
          m_deadline++;
          if (m_run == TO - 1) begin m_flag = 1; m_run = 0; end
          else m_run++;
        end else m_run = 0;
        if (m_k == m_deadline) begin
          m_ps = 1; m_bs = (m_phase == 3);
          m_phase = (m_phase + 1) % 4;
          if (m_bs) m_div = eff;
          m_deadline = m_k + m_div;
        end
        m_frozen = stretch_en_i && !m_flag && m_phase == 2 &&
                   (m_k == m_deadline - m_div) && !m_s2;
      end
    end
  end

  always @(negedge clk_10MHz) begin
    if (chk_on) begin
      check("phase", phase_o, m_phase);
      check("phase_strobe", phase_strobe_o, m_ps);
      check("bit_strobe", bit_strobe_o, m_bs);
      check("stretching", stretching_o, m_frozen);
      check("timeout_flag", stretch_timeout_o, m_flag);
      check("div_active", div_active_o, m_div);
      check("led", led, m_led[LW-1]);
    end
  end

  function automatic bit pulse(input int which);
    return (which == 0) ? phase_strobe_o : bit_strobe_o;
  endfunction

  task automatic until_pulse(input int which, output int n);
    n = 0;
    do begin
      @(negedge clk_10MHz); n++;
    end while (!pulse(which) && n < 3000);
  endtask

  task automatic gap(input int which, input int exp, input string name);
    int n;
    until_pulse(which, n);
    if (n >= 3000) begin check({name, "_start"}, n, 0); return; end
    until_pulse(which, n);
    check(name, n, exp);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seen;
    chk_on = 1'b1;
    repeat (3) @(negedge clk_10MHz);
    check("rst_div", div_active_o, 25);
    check("rst_phase", phase_o, 0);
    areset_n = 1'b1;

    // Standard mode periods and phase order
    gap(0, 25, "ps_period_std");
    gap(1, 100, "bit_period_std");
    for (int i = 1; i <= 3; i++) begin
      until_pulse(0, n);
      check("phase_seq", phase_o, i);
    end

    // Mode change in phase 1 takes effect only at the bit boundary
    until_pulse(1, n);
    n = 0;
    do begin
      @(negedge clk_10MHz); n++;
      if (n == 30) mode_i = 1'b1;
      if (n == 99) check("div_before_boundary", div_active_o, 25);
    end while (!bit_strobe_o && n < 3000);
    check("bit_across_mode_change", n, 100);
    check("div_at_boundary", div_active_o, 7);
    until_pulse(1, n);
    check("bit_period_fast", n, 28);

    // Override clamp and large override
    div_override_i = 8'd1;
    until_pulse(1, n);
    check("div_clamped", div_active_o, 2);
    gap(0, 2, "ps_period_ovr1");
    div_override_i = 8'd40;
    mode_i = 1'($urandom_range(0, 1));
    until_pulse(1, n);
    gap(1, 160, "bit_period_ovr40");

    // Stretch: SCL held low through phases 0/1 and 300 cycles into phase 2
    div_override_i = '0; mode_i = 1'b0;
    until_pulse(1, n);
    stretch_en_i = 1'b1; scl_in_i = 1'b0;
    n = 0;
    do begin until_pulse(0, seen); n++; end while (phase_o != 2 && n < 8);
    seen = 0; n = 0;
    do begin
      @(negedge clk_10MHz); n++;
      if (stretching_o) seen++;
      if (n == 300) scl_in_i = 1'b1;
    end while (!phase_strobe_o && n < 3000);
    check("phase2_stretched_len", n, 327);
    check("stretched_cycles", seen, 301);
    check("no_timeout_after_stretch", stretch_timeout_o, 0);
    gap(1, 100, "bit_after_stretch");

    // Permanent low SCL: timeout after TO frozen cycles, then no more freezes
    scl_in_i = 1'b0;
    n = 0;
    while (!stretching_o && n < 500) begin @(negedge clk_10MHz); n++; end
    n = 0;
    while (stretching_o && n < 2000) begin @(negedge clk_10MHz); n++; end
    check("frozen_before_timeout", n, TO);
    check("timeout_set", stretch_timeout_o, 1);
    seen = 0;
    repeat (250) begin @(negedge clk_10MHz); if (stretching_o) seen++; end
    check("no_freeze_after_timeout", seen, 0);
    check("timeout_sticky", stretch_timeout_o, 1);
    enable_i = 1'b0;
    @(negedge clk_10MHz);
    check("timeout_cleared", stretch_timeout_o, 0);
    check("div_while_disabled", div_active_o, 25);
    scl_in_i = 1'b1; enable_i = 1'b1;
    until_pulse(0, n);
    check("reenable_first_strobe", n, 25);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      @(negedge clk_10MHz);
      r = int'($urandom_range(0, 99));
      if (r < 1) enable_i = 1'b0;
      else if (!enable_i && r < 30) enable_i = 1'b1;
      if (r >= 2 && r < 4) mode_i = ~mode_i;
      if (r == 5) begin
        case ($urandom_range(0, 6))
          0, 1, 2: div_override_i = '0;
          3: div_override_i = 8'd1;
          4: div_override_i = 8'd3;
          5: div_override_i = 8'($urandom_range(0, 12));
          default: div_override_i = 8'($urandom_range(0, 255));
        endcase
      end
      if (r == 6) stretch_en_i = ~stretch_en_i;
      if ($urandom_range(0, 99) < 2) scl_in_i = ~scl_in_i;
    end

    // Asynchronous reset in phase 3
    enable_i = 1'b1; mode_i = 1'b0; div_override_i = '0; stretch_en_i = 1'b0; scl_in_i = 1'b1;
    n = 0;
    while (phase_o != 3 && n < 3000) begin @(negedge clk_10MHz); n++; end
    @(negedge clk_10MHz);
    #20 areset_n = 1'b0;
    #1;
    check("arst_phase", phase_o, 0);
    check("arst_ps", phase_strobe_o, 0);
    check("arst_bs", bit_strobe_o, 0);
    check("arst_stretching", stretching_o, 0);
    check("arst_timeout", stretch_timeout_o, 0);
    check("arst_div", div_active_o, 25);
    check("arst_led", led, 0);
    repeat (2) @(negedge clk_10MHz);
    areset_n = 1'b1;
    n = 0;
    while (!led && n < 1000) begin @(negedge clk_10MHz); n++; end
    check("led_first_toggle", n, 128);
    n = 0;
    do begin @(negedge clk_10MHz); n++; end while (led && n < 1000);
    check("led_toggle_period", n, 128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
